fft_top_cmul_pipe: RTL and testbench

Parametrised, fully pipelined signed complex multiplier for the FFT datapath. It multiplies a data sample by a twiddle factor, or by its conjugate when selected per sample. The result is rounded, shifted and saturated to a programmable output width. It accepts one sample per cycle behind a valid flag and a global clock enable. It sits between the twiddle ROM and the butterfly adders, and is the successor of the single real-multiply DSP wrapper.

---
 rtl/fft_top_cmul_pipe.sv | 185 ++++++++++++++++++
 tb/tb_fft_top_cmul_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_top_cmul_pipe.sv
// Pipelined signed complex multiplier (optionally by the conjugate twiddle) with
// round-half-up, arithmetic shift, saturation and a configurable output delay line.
module fft_top_cmul_pipe #(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 15,
  parameter int OUT_WIDTH = 20,
  parameter int SHIFT     = 14,
  parameter int LATENCY   = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic                        conj,
  input  logic signed [A_WIDTH-1:0]   a_re,
  input  logic signed [A_WIDTH-1:0]   a_im,
  input  logic signed [B_WIDTH-1:0]   b_re,
  input  logic signed [B_WIDTH-1:0]   b_im,
  input  logic                        clr_sat,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] p_re,
  output logic signed [OUT_WIDTH-1:0] p_im,
  output logic                        sat,
  output logic                        sat_sticky
);

  localparam int PW   = A_WIDTH + B_WIDTH;
  localparam int M    = PW + 1;
  // Rounding/clamp width covers both the rounded product and the output range.
  localparam int CW   = ((M + 1 > OUT_WIDTH) ? M + 1 : OUT_WIDTH) + 1;
  localparam int NDLY = LATENCY - 4;

  localparam logic signed [CW-1:0] ONE  = CW'(1);
  localparam logic signed [CW-1:0] RND  = ONE <<< (SHIFT - 1);
  localparam logic signed [CW-1:0] MAXV = (ONE <<< (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [CW-1:0] MINV = -(ONE <<< (OUT_WIDTH - 1));

  // S1: registered operands, index 0 = real, 1 = imaginary
  logic                      s1_valid_reg;
  logic                      s1_conj_reg;
  logic signed [A_WIDTH-1:0] s1_a_reg [2];
  logic signed [B_WIDTH-1:0] s1_b_reg [2];

  always_ff @(posedge clk) begin
    if (!reset_n)
      s1_valid_reg <= 1'b0;
    else if (ce)
      s1_valid_reg <= in_valid;
    if (ce) begin
      s1_conj_reg <= conj;
      s1_a_reg[0] <= a_re;
      s1_a_reg[1] <= a_im;
      s1_b_reg[0] <= b_re;
      s1_b_reg[1] <= b_im;
    end
  end

  // S2: partial products rr, ii, ir, ri
  logic signed [PW-1:0] a_ext [2];
  logic signed [PW-1:0] b_ext [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ext
      assign a_ext[gi] = {{B_WIDTH{s1_a_reg[gi][A_WIDTH-1]}}, s1_a_reg[gi]};
      assign b_ext[gi] = {{A_WIDTH{s1_b_reg[gi][B_WIDTH-1]}}, s1_b_reg[gi]};
    end
  endgenerate

  logic                 s2_valid_reg;
  logic                 s2_conj_reg;
  logic signed [PW-1:0] s2_pp_reg [4];

  always_ff @(posedge clk) begin
    if (!reset_n)
      s2_valid_reg <= 1'b0;
    else if (ce)
      s2_valid_reg <= s1_valid_reg;
    if (ce) begin
      s2_conj_reg  <= s1_conj_reg;
      s2_pp_reg[0] <= a_ext[0] * b_ext[0];
      s2_pp_reg[1] <= a_ext[1] * b_ext[1];
      s2_pp_reg[2] <= a_ext[1] * b_ext[0];
      s2_pp_reg[3] <= a_ext[0] * b_ext[1];
    end
  end

  // S3: combine; conj flips the sign of the b_im terms
  logic signed [M-1:0] pp_ext [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pp
      assign pp_ext[gi] = {s2_pp_reg[gi][PW-1], s2_pp_reg[gi]};
    end
  endgenerate

  logic                s3_valid_reg;
  logic signed [M-1:0] s3_sum_reg [2];

  always_ff @(posedge clk) begin
    if (!reset_n)
      s3_valid_reg <= 1'b0;
    else if (ce)
      s3_valid_reg <= s2_valid_reg;
    if (ce) begin
      if (s2_conj_reg) begin
        s3_sum_reg[0] <= pp_ext[0] + pp_ext[1];
        s3_sum_reg[1] <= pp_ext[2] - pp_ext[3];
      end else begin
        s3_sum_reg[0] <= pp_ext[0] - pp_ext[1];
        s3_sum_reg[1] <= pp_ext[2] + pp_ext[3];
      end
    end
  end

  // S4 combinational: round half up, shift, clamp
  logic signed [CW-1:0]        rnd_w  [2];
  logic signed [CW-1:0]        shf_w  [2];
  logic signed [OUT_WIDTH-1:0] clip_w [2];
  logic [1:0]                  hi_w;
  logic [1:0]                  lo_w;
  logic                        sat_w;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
      assign rnd_w[gi]  = {{(CW-M){s3_sum_reg[gi][M-1]}}, s3_sum_reg[gi]} + RND;
      assign shf_w[gi]  = rnd_w[gi] >>> SHIFT;
      assign hi_w[gi]   = (shf_w[gi] > MAXV);
      assign lo_w[gi]   = (shf_w[gi] < MINV);
      assign clip_w[gi] = hi_w[gi] ? MAXV[OUT_WIDTH-1:0] :
                          lo_w[gi] ? MINV[OUT_WIDTH-1:0] :
                                     shf_w[gi][OUT_WIDTH-1:0];
    end
  endgenerate

  assign sat_w = |hi_w | |lo_w;

  // S4 register is element 0; elements 1..NDLY are the trailing delay line
  logic                        dly_valid_reg [0:NDLY];
  logic                        dly_sat_reg   [0:NDLY];
  logic signed [OUT_WIDTH-1:0] dly_re_reg    [0:NDLY];
  logic signed [OUT_WIDTH-1:0] dly_im_reg    [0:NDLY];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i <= NDLY; i++)
        dly_valid_reg[i] <= 1'b0;
    end else if (ce) begin
      dly_valid_reg[0] <= s3_valid_reg;
      for (int i = 1; i <= NDLY; i++)
        dly_valid_reg[i] <= dly_valid_reg[i-1];
    end
    if (ce) begin
      dly_sat_reg[0] <= sat_w;
      dly_re_reg[0]  <= clip_w[0];
      dly_im_reg[0]  <= clip_w[1];
      for (int i = 1; i <= NDLY; i++) begin
        dly_sat_reg[i] <= dly_sat_reg[i-1];
        dly_re_reg[i]  <= dly_re_reg[i-1];
        dly_im_reg[i]  <= dly_im_reg[i-1];
      end
    end
  end

  assign out_valid = dly_valid_reg[NDLY];
  assign p_re      = out_valid ? dly_re_reg[NDLY] : '0;
  assign p_im      = out_valid ? dly_im_reg[NDLY] : '0;
  assign sat       = out_valid & dly_sat_reg[NDLY];

  // A saturated result arriving in the same cycle as clr_sat keeps the flag set
  logic sat_sticky_reg;

  always_ff @(posedge clk) begin
    if (!reset_n)
      sat_sticky_reg <= 1'b0;
    else if (ce) begin
      if (sat)
        sat_sticky_reg <= 1'b1;
      else if (clr_sat)
        sat_sticky_reg <= 1'b0;
    end
  end

  assign sat_sticky = sat_sticky_reg;

endmodule

// File: tb/tb_fft_top_cmul_pipe.sv
// Scoreboard bench: two DUT configurations share one stimulus stream; each has its
// own predictor queue and monitor comparing every cycle against an arithmetic model.
module tb_fft_top_cmul_pipe;

  localparam int AW = 20;
  localparam int BW = 15;
  localparam int SH = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n;
  logic                 ce;
  logic                 in_valid;
  logic                 conj;
  logic                 clr_sat;
  logic signed [AW-1:0] a_re;
  logic signed [AW-1:0] a_im;
  logic signed [BW-1:0] b_re;
  logic signed [BW-1:0] b_im;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    longint re;
    longint im;
    bit     sat;
    int     due;
  } exp_t;

  task automatic check(input string name, input int d, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, d, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input int ow, output bit s);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (ow - 1)) - 1;
    lo = -(64'sd1 <<< (ow - 1));
    s = 1'b0;
    if (v > hi) begin s = 1'b1; return hi; end
    if (v < lo) begin s = 1'b1; return lo; end
    return v;
  endfunction

  // Exact complex product, then round-half-up and floor shift, then clamp.
  task automatic model(input longint ar, input longint ai, input longint br, input longint bi,
                       input bit cj, input int ow, output longint pr, output longint pi,
                       output bit s);
    longint re;
    longint im;
    bit s_re;
    bit s_im;
    re = cj ? ar * br + ai * bi : ar * br - ai * bi;
    im = cj ? ai * br - ar * bi : ai * br + ar * bi;
    re = (re + (64'sd1 <<< (SH - 1))) >>> SH;
    im = (im + (64'sd1 <<< (SH - 1))) >>> SH;
    pr = clamp(re, ow, s_re);
    pi = clamp(im, ow, s_im);
    s  = s_re | s_im;
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 4 : 7;
      localparam int OW  = (gi == 0) ? 20 : 24;

      logic                 ov;
      logic                 s;
      logic                 ss;
      logic signed [OW-1:0] pr;
      logic signed [OW-1:0] pi;

      fft_top_cmul_pipe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW), .SHIFT(SH), .LATENCY(LAT)
      ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .conj(conj),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .clr_sat(clr_sat),
        .out_valid(ov), .p_re(pr), .p_im(pi), .sat(s), .sat_sticky(ss)
      );

      exp_t q[$];
      exp_t cur;
      bit   cur_v    = 1'b0;
      bit   sticky_m = 1'b0;
      int   en_cnt   = 0;

      always @(posedge clk) begin
        exp_t e;
        if (!reset_n) begin
          q.delete();
          cur_v    = 1'b0;
          sticky_m = 1'b0;
        end else if (ce) begin
          if (cur_v && cur.sat)
            sticky_m = 1'b1;
          else if (clr_sat)
            sticky_m = 1'b0;
          en_cnt++;
          if (in_valid) begin
            model(a_re, a_im, b_re, b_im, conj, OW, e.re, e.im, e.sat);
            e.due = en_cnt + LAT - 1;
            q.push_back(e);
          end
          cur_v = 1'b0;
          if (q.size() > 0 && q[0].due == en_cnt) begin
            cur   = q.pop_front();
            cur_v = 1'b1;
          end
        end
        #1;
        check("out_valid", gi, longint'(ov), longint'(cur_v));
        check("p_re", gi, longint'(pr), cur_v ? cur.re : 64'sd0);
        check("p_im", gi, longint'(pi), cur_v ? cur.im : 64'sd0);
        check("sat", gi, longint'(s), cur_v ? longint'(cur.sat) : 64'sd0);
        check("sat_sticky", gi, longint'(ss), longint'(sticky_m));
        if (ov && ce && reset_n)
          $display("dut%0d out re=%0d im=%0d sat=%0d sticky=%0d", gi, pr, pi, s, ss);
      end
    end
  endgenerate

  task automatic drive(input bit v, input bit cj, input longint ar, input longint ai,
                       input longint br, input longint bi);
    @(negedge clk);
    in_valid = v;
    conj     = cj;
    a_re     = AW'(ar);
    a_im     = AW'(ai);
    b_re     = BW'(br);
    b_im     = BW'(bi);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drive_rand();
    @(negedge clk);
    in_valid = 1'b1;
    conj     = 1'($urandom);
    a_re     = AW'($urandom);
    a_im     = AW'($urandom);
    b_re     = BW'($urandom);
    b_im     = BW'($urandom);
  endtask

  initial begin
    reset_n  = 1'b0;
    ce       = 1'b1;
    in_valid = 1'b0;
    conj     = 1'b0;
    clr_sat  = 1'b0;
    a_re     = '0;
    a_im     = '0;
    b_re     = '0;
    b_im     = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // basic, conjugate, rounding
    drive(1, 0, 1000, -500, 8192, 0);
    drive(1, 1, 1000, -500, 0, 8192);
    drive(1, 0, 1000, -500, 0, 8192);
    drive(1, 0, 3, 0, 8192, 0);
    drive(1, 0, -3, 0, 8192, 0);
    drive(1, 0, 1, 0, 8192, 0);
    idle(8);

    // saturation corner, sticky hold and clear
    drive(1, 0, -524288, -524288, -16384, 16384);
    idle(8);
    @(negedge clk);
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    idle(2);

    // saturation arriving while clr_sat is held
    drive(1, 0, -524288, -524288, -16384, 16384);
    @(negedge clk);
    in_valid = 1'b0;
    clr_sat  = 1'b1;
    idle(10);
    clr_sat = 1'b0;

    // 16 back-to-back samples with a 3-cycle stall mid-stream
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        @(negedge clk);
        ce = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        ce = 1'b1;
        in_valid = 1'b0;
      end
      drive_rand();
    end
    idle(12);

    // random enable, valid and clear
    for (int i = 0; i < 40; i++) begin
      drive_rand();
      in_valid = 1'($urandom);
      ce       = ($urandom_range(0, 3) != 0);
      clr_sat  = ($urandom_range(0, 7) == 0);
      if (i % 5 == 0) begin
        a_re = AW'(-524288);
        a_im = AW'(-524288);
      end
    end
    @(negedge clk);
    ce      = 1'b1;
    clr_sat = 1'b0;
    idle(12);

    // reset with three samples in flight
    drive_rand();
    drive_rand();
    drive_rand();
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
